// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port 0 is the CPU, port 1 the loader/debug port. Grants are combinational
// from the requests and registered arbitration state; read data returns one
// cycle after the granted read on a shared rdata bus qualified by rvalidN.
module mem_arbiter #(
    parameter int RR_MODE  = 1,   // 1: round-robin, 0: fixed priority to port 0
    parameter int MAX_WAIT = 4    // 1..15: denied cycles before port 1 is forced in
) (
    input  logic       clk,
    input  logic       rst,       // synchronous, active-low
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_rden,
    output logic       ram_wren,
    input  logic [7:0] ram_q
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    logic       last_gnt;  // 1: port 1 was granted most recently
    logic [3:0] wait_cnt;  // consecutive cycles port 1 has been denied
    logic [7:0] rdata_q;   // last returned read data, held between reads

    // Grant selection; no grant at all while reset is asserted.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (RR_MODE != 0) begin
                if (req0 && req1) begin
                    // Tie: the port that did not win last time goes now.
                    gnt0 = last_gnt;
                    gnt1 = !last_gnt;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end else begin
                if (req1 && (wait_cnt == MAX_WAIT_L)) begin
                    gnt1 = 1'b1;   // starvation guard overrides the CPU
                end else if (req0) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = req1;
                end
            end
        end
    end

    // RAM command mux: the granted port drives the RAM, idle drives zeros.
    always_comb begin
        ram_addr = 8'h00;
        ram_data = 8'h00;
        ram_rden = 1'b0;
        ram_wren = 1'b0;
        if (gnt0) begin
            ram_addr = addr0;
            ram_data = wdata0;
            ram_wren = we0;
            ram_rden = !we0;
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_data = wdata1;
            ram_wren = we1;
            ram_rden = !we1;
        end
    end

    // While a read is returning, rdata follows the RAM; otherwise it holds.
    assign rdata = (rvalid0 || rvalid1) ? ram_q : rdata_q;

    // Arbitration state, read-return tracking and rdata hold register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            last_gnt <= 1'b1;      // port 0 wins the first tie after reset
            wait_cnt <= 4'd0;
            rvalid0  <= 1'b0;      // a read issued just before reset is dropped
            rvalid1  <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;

            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
            end

            if (!req1 || gnt1) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'd15) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (rvalid0 || rvalid1) begin
                rdata_q <= ram_q;
            end
        end
    end

endmodule
